// File: rtl/irq_pkg.sv
// Shared constants and state encoding for the interrupt controller.
// The state enum is also exported on a debug port so checkers can bind to it.
package irq_pkg;

    localparam int NUM_IRQ_MAX = 8;
    localparam int IRQ_ID_W    = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: 2-flop synchronizer, previous-value flop and rising-edge pulse.
// A line already high when reset is released is not an event until it has been seen low.
module irq_sync_edge (
    input  logic CLK,
    input  logic RST,
    input  logic irq_async,
    output logic irq_edge
);

    logic sync1;
    logic sync2;
    logic prev;
    logic started;
    logic armed;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            prev    <= 1'b0;
            started <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sync1   <= irq_async;
            sync2   <= sync1;
            prev    <= sync2;
            started <= 1'b1;
            // sync1 holds a real post-reset sample once started is set
            if (started && !sync1) begin
                armed <= 1'b1;
            end
        end
    end

    assign irq_edge = sync2 & ~prev & armed;

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller: pending latches, enable mask, lowest-index
// priority and an IDLE/REQ/SERVICE handshake with the MCU (no nesting).
// Handshake: INTR is held while in REQ until INT_TAKEN (accept) or MIE drops (withdraw);
// IRQ_ACTIVE is held while in SERVICE until CSR_MRET.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_IRQ-1:0]  IRQ_IN,
    input  logic                MIE,
    input  logic                INT_TAKEN,
    input  logic                CSR_MRET,
    input  logic                MASK_WR,
    input  logic [NUM_IRQ-1:0]  MASK_WD,
    output logic                INTR,
    output logic [IRQ_ID_W-1:0] IRQ_ID,
    output logic                IRQ_ACTIVE,
    output logic [NUM_IRQ-1:0]  PENDING,
    output logic [NUM_IRQ-1:0]  MASK,
    output irq_state_t          STATE
);

    if (NUM_IRQ > NUM_IRQ_MAX || NUM_IRQ < 1) begin : g_bad_num_irq
        $error("irq_controller: NUM_IRQ out of range");
    end

    logic [NUM_IRQ-1:0]  irq_edge;
    logic [NUM_IRQ-1:0]  req_vec;
    logic [NUM_IRQ-1:0]  clr_vec;
    logic [IRQ_ID_W-1:0] sel_id;
    logic [IRQ_ID_W-1:0] id_nxt;
    irq_state_t          state;
    irq_state_t          state_nxt;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
        irq_sync_edge u_sync_edge (
            .CLK       (CLK),
            .RST       (RST),
            .irq_async (IRQ_IN[g]),
            .irq_edge  (irq_edge[g])
        );
    end

    assign req_vec = PENDING & MASK;

    // Scan from the top so the lowest enabled pending index wins.
    always_comb begin
        sel_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                sel_id = IRQ_ID_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        id_nxt    = IRQ_ID;
        clr_vec   = '0;
        case (state)
            IDLE: begin
                if (MIE && (|req_vec)) begin
                    state_nxt = REQ;
                    id_nxt    = sel_id;
                end
            end
            REQ: begin
                if (INT_TAKEN) begin
                    state_nxt = SERVICE;
                    for (int i = 0; i < NUM_IRQ; i++) begin
                        clr_vec[i] = (IRQ_ID == IRQ_ID_W'(i));
                    end
                end else if (!MIE) begin
                    state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (CSR_MRET) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            IRQ_ID  <= '0;
            PENDING <= '0;
            MASK    <= '0;
        end else begin
            state   <= state_nxt;
            IRQ_ID  <= id_nxt;
            // A fresh edge on the line being acknowledged re-sets it.
            PENDING <= (PENDING & ~clr_vec) | irq_edge;
            if (MASK_WR) begin
                MASK <= MASK_WD;
            end
        end
    end

    assign INTR       = (state == REQ);
    assign IRQ_ACTIVE = (state == SERVICE);
    assign STATE      = state;

endmodule

// File: tb/tb_irq_controller.sv
// Directed scenarios plus randomized traffic for irq_controller, checked every cycle
// against a sample-history reference model.
module tb_irq_controller;
    import irq_pkg::*;

    logic       CLK;
    logic       rst;
    logic [7:0] irq_in;
    logic       mie;
    logic       int_taken;
    logic       csr_mret;
    logic       mask_wr;
    logic [7:0] mask_wd;

    logic       INTR;
    logic [2:0] IRQ_ID;
    logic       IRQ_ACTIVE;
    logic [7:0] PENDING;
    logic [7:0] MASK;
    irq_state_t STATE;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: state 0=idle 1=requesting 2=in service
    int         m_state;
    int         m_id;
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    // Input samples of the last three edges (index 0 newest); invalid if taken in or before reset
    logic [7:0] h_d [3];
    logic       h_v [3];
    logic [2:0] exp_q [$];

    irq_controller #(.NUM_IRQ(8)) dut (
        .CLK        (CLK),
        .RST        (rst),
        .IRQ_IN     (irq_in),
        .MIE        (mie),
        .INT_TAKEN  (int_taken),
        .CSR_MRET   (csr_mret),
        .MASK_WR    (mask_wr),
        .MASK_WD    (mask_wd),
        .INTR       (INTR),
        .IRQ_ID     (IRQ_ID),
        .IRQ_ACTIVE (IRQ_ACTIVE),
        .PENDING    (PENDING),
        .MASK       (MASK),
        .STATE      (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // A line is pending-set when, among post-reset samples, it went 0 then 1,
    // the 1 being two edges old.
    task automatic model_step();
        logic [7:0] set_v;
        logic [7:0] clr_v;
        logic [7:0] req;
        if (rst) begin
            m_state = 0;
            m_id    = 0;
            m_pend  = '0;
            m_mask  = '0;
            for (int i = 0; i < 3; i++) begin
                h_v[i] = 1'b0;
                h_d[i] = '0;
            end
        end else begin
            set_v = (h_v[1] && h_v[2]) ? (h_d[1] & ~h_d[2]) : 8'h00;
            clr_v = '0;
            req   = m_pend & m_mask;
            case (m_state)
                0: if (mie && req != 0) begin
                    m_state = 1;
                    m_id    = lowest(req);
                end
                1: if (int_taken) begin
                    m_state = 2;
                    clr_v   = 8'h01 << m_id;
                    exp_q.push_back(3'(m_id));
                end else if (!mie) begin
                    m_state = 0;
                end
                2: if (csr_mret) m_state = 0;
                default: m_state = 0;
            endcase
            m_pend = (m_pend & ~clr_v) | set_v;
            if (mask_wr) m_mask = mask_wd;
            h_d[2] = h_d[1]; h_v[2] = h_v[1];
            h_d[1] = h_d[0]; h_v[1] = h_v[0];
        end
        h_d[0] = irq_in;
        h_v[0] = !rst;
    endtask

    task automatic tick();
        logic [2:0] e_id;
        @(posedge CLK);
        model_step();
        #1;
        check("intr", INTR, (m_state == 1));
        check("active", IRQ_ACTIVE, (m_state == 2));
        check("state", STATE, m_state);
        check("irq_id", IRQ_ID, m_id);
        check("pending", PENDING, m_pend);
        check("mask", MASK, m_mask);
        if (exp_q.size() > 0) begin
            e_id = exp_q.pop_front();
            check("svc_id", IRQ_ID, e_id);
        end
        int_taken = 1'b0;
        csr_mret  = 1'b0;
        mask_wr   = 1'b0;
    endtask

    task automatic set_mask(input logic [7:0] v);
        mask_wr = 1'b1;
        mask_wd = v;
        tick();
    endtask

    // One-cycle pulse: the edges taken are N and N+1
    task automatic pulse(input logic [7:0] bits);
        irq_in = bits;
        tick();
        irq_in = '0;
        tick();
    endtask

    task automatic ack_and_return();
        int_taken = 1'b1;
        tick();
        csr_mret = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; irq_in = '0; mie = 1'b0; int_taken = 1'b0;
        csr_mret = 1'b0; mask_wr = 1'b0; mask_wd = '0;
        m_state = 0; m_id = 0; m_pend = '0; m_mask = '0;
        for (int i = 0; i < 3; i++) begin
            h_v[i] = 1'b0;
            h_d[i] = '0;
        end

        tick();
        tick();
        check("rst_intr", INTR, 0);
        check("rst_id", IRQ_ID, 0);
        check("rst_active", IRQ_ACTIVE, 0);
        check("rst_pend", PENDING, 0);
        rst = 1'b0;
        repeat (4) tick();

        // Single line, basic latency
        mie = 1'b1;
        set_mask(8'h01);
        pulse(8'h01);
        tick();
        check("t1_pend", PENDING, 8'h01);
        check("t1_intr_early", INTR, 0);
        tick();
        check("t1_intr", INTR, 1);
        check("t1_id", IRQ_ID, 0);

        // Acknowledge and return
        int_taken = 1'b1;
        tick();
        check("t2_intr", INTR, 0);
        check("t2_active", IRQ_ACTIVE, 1);
        check("t2_pend", PENDING, 8'h00);
        csr_mret = 1'b1;
        tick();
        check("t2_active_off", IRQ_ACTIVE, 0);

        // Simultaneous lines 5 and 2
        set_mask(8'hFF);
        pulse(8'h24);
        tick();
        check("t3_pend", PENDING, 8'h24);
        tick();
        check("t3_intr", INTR, 1);
        check("t3_id", IRQ_ID, 2);
        int_taken = 1'b1;
        tick();
        check("t3_pend_after_ack", PENDING, 8'h20);
        csr_mret = 1'b1;
        tick();
        check("t3_idle_intr", INTR, 0);
        tick();
        check("t3_second_intr", INTR, 1);
        check("t3_second_id", IRQ_ID, 5);
        ack_and_return();

        // Masked line stays pending, unmasking raises the request
        set_mask(8'h00);
        pulse(8'h08);
        tick();
        tick();
        check("t4_pend", PENDING, 8'h08);
        check("t4_masked_intr", INTR, 0);
        set_mask(8'h08);
        tick();
        check("t4_intr", INTR, 1);
        check("t4_id", IRQ_ID, 3);
        ack_and_return();

        // Withdraw via MIE
        set_mask(8'hFF);
        pulse(8'h40);
        tick();
        tick();
        check("t5_intr", INTR, 1);
        mie = 1'b0;
        tick();
        check("t5_withdrawn", INTR, 0);
        check("t5_pend", PENDING, 8'h40);
        mie = 1'b1;
        tick();
        check("t5_reraise", INTR, 1);
        check("t5_id", IRQ_ID, 6);
        ack_and_return();

        // New edge coinciding with the clear: set wins
        irq_in = 8'h10; tick();
        irq_in = 8'h00; tick();
        irq_in = 8'h10; tick();
        irq_in = 8'h00; tick();
        check("t6_intr", INTR, 1);
        check("t6_id", IRQ_ID, 4);
        int_taken = 1'b1;
        tick();
        check("t6_active", IRQ_ACTIVE, 1);
        check("t6_pend_set_wins", PENDING, 8'h10);
        csr_mret = 1'b1;
        tick();
        tick();
        check("t6_again", INTR, 1);
        ack_and_return();

        // Reset during service, line held high through and after reset
        pulse(8'h02);
        tick();
        tick();
        int_taken = 1'b1;
        tick();
        check("t7_in_service", IRQ_ACTIVE, 1);
        irq_in = 8'h80;
        rst    = 1'b1;
        tick();
        check("t7_intr", INTR, 0);
        check("t7_id", IRQ_ID, 0);
        check("t7_active", IRQ_ACTIVE, 0);
        check("t7_pend", PENDING, 0);
        check("t7_mask", MASK, 0);
        check("t7_state", STATE, IDLE);
        tick();
        rst = 1'b0;
        mask_wr = 1'b1;
        mask_wd = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t7_held_pend", PENDING, 0);
            check("t7_held_intr", INTR, 0);
        end
        irq_in = '0;
        repeat (4) tick();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 249) == 0);
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 9) == 0) irq_in[b] = ~irq_in[b];
            end
            mie = ($urandom_range(0, 7) != 0);
            if (m_state == 1) int_taken = ($urandom_range(0, 2) == 0);
            else              int_taken = ($urandom_range(0, 9) == 0);
            csr_mret = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin
                mask_wr = 1'b1;
                mask_wd = 8'($urandom_range(0, 255));
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
